// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator tile scheduler: FSM state encoding
// and default address/stride parameters.
package acc_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_ADV   = 3'd4,
      S_DONE  = 3'd5
   } sched_state_t;

   localparam int ACC_AW_DEFAULT         = 13;
   localparam int ACC_OUT_STRIDE_DEFAULT = 4;

endpackage

// File: rtl/acc_tile_sched.sv
// Tile scheduler: walks a row_tiles x col_tiles grid (column-inner) and issues one
// systolic-array start per tile. Define ACC_SCHED_PERF_EN to add the perf_cycles counter.
module acc_tile_sched
   import acc_pkg::*;
#(
   parameter int AW         = ACC_AW_DEFAULT,
   parameter int OUT_STRIDE = ACC_OUT_STRIDE_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          job_valid,
   output logic          job_ready,
   input  logic [7:0]    job_row_tiles,
   input  logic [7:0]    job_col_tiles,
   input  logic [7:0]    job_k,
   input  logic [AW-1:0] job_row_base,
   input  logic [AW-1:0] job_col_base,
   input  logic [AW-1:0] job_out_base,
   input  logic          job_out_mode,
   output logic          sa_start,
   output logic [7:0]    sa_k_param,
   output logic          sa_out_mode,
   output logic [AW-1:0] sa_row_addr,
   output logic [AW-1:0] sa_col_addr,
   output logic [AW-1:0] sa_out_addr,
   input  logic          sa_done,
   input  logic          abort,
   output logic          busy,
   output logic          job_done,
   output logic [15:0]   tile_cnt
`ifdef ACC_SCHED_PERF_EN
   ,
   output logic [31:0]   perf_cycles
`endif
);

   sched_state_t  state_reg, state_next;
   logic [7:0]    row_tiles_reg, col_tiles_reg, k_reg;
   logic [7:0]    r_reg, c_reg;
   logic [AW-1:0] row_base_reg, col_base_reg, out_base_reg;
   logic [AW-1:0] row_addr_reg, col_addr_reg, out_addr_reg;
   logic          out_mode_reg;
   logic [15:0]   tile_cnt_reg;

   logic accept, empty_job, last_col, last_tile, load_fire, adv_fire;

   assign accept    = job_valid && (state_reg == S_IDLE);
   assign empty_job = (row_tiles_reg == 8'd0) || (col_tiles_reg == 8'd0);
   assign last_col  = (c_reg == col_tiles_reg - 8'd1);
   assign last_tile = last_col && (r_reg == row_tiles_reg - 8'd1);
   assign load_fire = (state_reg == S_LOAD) && !abort;
   assign adv_fire  = (state_reg == S_ADV) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      job_ready  = 1'b0;
      busy       = 1'b1;
      sa_start   = 1'b0;
      job_done   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            job_ready = 1'b1;
            busy      = 1'b0;
            if (job_valid) state_next = S_LOAD;
         end
         S_LOAD:  state_next = empty_job ? S_DONE : S_START;
         S_START: begin
            sa_start   = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT:  if (sa_done) state_next = S_ADV;
         S_ADV:   state_next = last_tile ? S_DONE : S_START;
         S_DONE: begin
            job_done   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      // Cancel wins over any completion in the same cycle.
      if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_tiles_reg <= '0;
         col_tiles_reg <= '0;
         k_reg         <= '0;
         out_mode_reg  <= 1'b0;
         row_base_reg  <= '0;
         col_base_reg  <= '0;
         out_base_reg  <= '0;
         r_reg         <= '0;
         c_reg         <= '0;
         row_addr_reg  <= '0;
         col_addr_reg  <= '0;
         out_addr_reg  <= '0;
         tile_cnt_reg  <= '0;
      end else begin
         if (accept) begin
            row_tiles_reg <= job_row_tiles;
            col_tiles_reg <= job_col_tiles;
            k_reg         <= job_k;
            out_mode_reg  <= job_out_mode;
            row_base_reg  <= job_row_base;
            col_base_reg  <= job_col_base;
            out_base_reg  <= job_out_base;
         end
         if (load_fire) begin
            r_reg        <= '0;
            c_reg        <= '0;
            tile_cnt_reg <= '0;
            row_addr_reg <= row_base_reg;
            col_addr_reg <= col_base_reg;
            out_addr_reg <= out_base_reg;
         end
         if (adv_fire) begin
            tile_cnt_reg <= tile_cnt_reg + 16'd1;
            out_addr_reg <= out_addr_reg + AW'(OUT_STRIDE);
            if (last_col) begin
               c_reg        <= '0;
               col_addr_reg <= col_base_reg;
               r_reg        <= r_reg + 8'd1;
               row_addr_reg <= row_addr_reg + AW'(k_reg);
            end else begin
               c_reg        <= c_reg + 8'd1;
               col_addr_reg <= col_addr_reg + AW'(k_reg);
            end
         end
      end
   end

   assign sa_k_param  = k_reg;
   assign sa_out_mode = out_mode_reg;
   assign sa_row_addr = row_addr_reg;
   assign sa_col_addr = col_addr_reg;
   assign sa_out_addr = out_addr_reg;
   assign tile_cnt    = tile_cnt_reg;

`ifdef ACC_SCHED_PERF_EN
   logic [31:0] perf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      perf_reg <= '0;
      else if (load_fire)                              perf_reg <= '0;
      else if ((state_reg == S_WAIT) && (perf_reg != '1)) perf_reg <= perf_reg + 32'd1;
   end

   assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_acc_tile_sched.sv
// Self-checking bench for acc_tile_sched: directed scenarios plus randomized
// jobs checked against a nested-loop tile-order reference model.
module tb_acc_tile_sched;

   localparam int AW     = 13;
   localparam int STRIDE = 4;
   localparam int AMASK  = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          job_valid;
   logic          job_ready;
   logic [7:0]    job_row_tiles, job_col_tiles, job_k;
   logic [AW-1:0] job_row_base, job_col_base, job_out_base;
   logic          job_out_mode;
   logic          sa_start;
   logic [7:0]    sa_k_param;
   logic          sa_out_mode;
   logic [AW-1:0] sa_row_addr, sa_col_addr, sa_out_addr;
   logic          sa_done;
   logic          abort;
   logic          busy;
   logic          job_done;
   logic [15:0]   tile_cnt;

   int compared   = 0;
   int mismatched = 0;

   // Observations collected by run_job
   int obs_row[$], obs_col[$], obs_out[$], obs_k[$], obs_mode[$];
   int obs_start_cycle, obs_done_cycle, obs_done_cnt, obs_busy_low, obs_tile_cnt;
   bit obs_timeout, obs_ready;

   acc_tile_sched #(.AW(AW), .OUT_STRIDE(STRIDE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_row_tiles (job_row_tiles),
      .job_col_tiles (job_col_tiles),
      .job_k         (job_k),
      .job_row_base  (job_row_base),
      .job_col_base  (job_col_base),
      .job_out_base  (job_out_base),
      .job_out_mode  (job_out_mode),
      .sa_start      (sa_start),
      .sa_k_param    (sa_k_param),
      .sa_out_mode   (sa_out_mode),
      .sa_row_addr   (sa_row_addr),
      .sa_col_addr   (sa_col_addr),
      .sa_out_addr   (sa_out_addr),
      .sa_done       (sa_done),
      .abort         (abort),
      .busy          (busy),
      .job_done      (job_done),
      .tile_cnt      (tile_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive_accept(input int rows, input int cols, input int k,
                               input int rb, input int cb, input int ob, input int mode);
      @(negedge clk);
      job_valid     = 1'b1;
      job_row_tiles = 8'(rows);
      job_col_tiles = 8'(cols);
      job_k         = 8'(k);
      job_row_base  = AW'(rb);
      job_col_base  = AW'(cb);
      job_out_base  = AW'(ob);
      job_out_mode  = 1'(mode);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (sa_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Acts as the systolic array: answers each start with sa_done after a random delay.
   task automatic run_job(input int rows, input int cols, input int k, input int rb,
                          input int cb, input int ob, input int mode, input int maxlat);
      int wait_cnt;
      int cyc;
      obs_row.delete(); obs_col.delete(); obs_out.delete(); obs_k.delete(); obs_mode.delete();
      obs_start_cycle = -1;
      obs_done_cycle  = -1;
      obs_done_cnt    = 0;
      obs_busy_low    = 0;
      obs_timeout     = 1'b0;
      drive_accept(rows, cols, k, rb, cb, ob, mode);
      wait_cnt = 0;
      cyc      = 0;
      while (obs_done_cnt == 0 && cyc < 400) begin
         sa_done = 1'b0;
         if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) sa_done = 1'b1;
         end
         if (busy !== 1'b1) obs_busy_low++;
         if (sa_start === 1'b1) begin
            obs_row.push_back(int'(sa_row_addr));
            obs_col.push_back(int'(sa_col_addr));
            obs_out.push_back(int'(sa_out_addr));
            obs_k.push_back(int'(sa_k_param));
            obs_mode.push_back(int'(sa_out_mode));
            if (obs_start_cycle < 0) obs_start_cycle = cyc;
            wait_cnt = 1 + $urandom_range(0, maxlat);
         end
         if (job_done === 1'b1) begin
            obs_done_cnt++;
            obs_done_cycle = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      sa_done = 1'b0;
      if (obs_done_cnt == 0) obs_timeout = 1'b1;
      if (job_done === 1'b1) obs_done_cnt++;
      obs_tile_cnt = int'(tile_cnt);
      obs_ready    = job_ready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; job_valid = 1'b0; sa_done = 1'b0; abort = 1'b0;
      job_row_tiles = '0; job_col_tiles = '0; job_k = '0;
      job_row_base = '0; job_col_base = '0; job_out_base = '0; job_out_mode = 1'b0;
      #1;
      compared++;
      if ({job_ready, busy, sa_start, job_done} !== 4'b1000) begin
         mismatched++;
         $display("FAIL reset_ctrl: got ready/busy/start/done=%b required 1000",
                  {job_ready, busy, sa_start, job_done});
      end
      compared++;
      if (tile_cnt !== 16'd0 || sa_k_param !== 8'd0 || sa_out_mode !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_cfg: got tile_cnt=%0h k=%0h mode=%b required 0", tile_cnt, sa_k_param, sa_out_mode);
      end
      compared++;
      if (sa_row_addr !== '0 || sa_col_addr !== '0 || sa_out_addr !== '0) begin
         mismatched++;
         $display("FAIL reset_addr: got %0h/%0h/%0h required 0", sa_row_addr, sa_col_addr, sa_out_addr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      $display("test_reset: done");
   endtask

   task automatic test_basic();
      int exp_row[6] = '{'h100, 'h100, 'h100, 'h108, 'h108, 'h108};
      int exp_col[6] = '{'h200, 'h208, 'h210, 'h200, 'h208, 'h210};
      run_job(2, 3, 8, 'h100, 'h200, 'h300, 1, 2);
      compared++;
      if (obs_row.size() != 6 || obs_timeout) begin
         mismatched++;
         $display("FAIL basic_starts: got %0d starts (timeout=%0b) required 6", obs_row.size(), obs_timeout);
      end else begin
         for (int i = 0; i < 6; i++) begin
            compared++;
            if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] || obs_out[i] != 'h300 + 4 * i ||
                obs_k[i] != 8 || obs_mode[i] != 1) begin
               mismatched++;
               $display("FAIL basic_tile%0d: got row=%0h col=%0h out=%0h k=%0d mode=%0d required %0h %0h %0h 8 1",
                        i, obs_row[i], obs_col[i], obs_out[i], obs_k[i], obs_mode[i],
                        exp_row[i], exp_col[i], 'h300 + 4 * i);
            end
         end
      end
      compared++;
      if (obs_tile_cnt != 6 || obs_done_cnt != 1 || obs_start_cycle != 1 || obs_busy_low != 0 || !obs_ready) begin
         mismatched++;
         $display("FAIL basic_status: got tile_cnt=%0d done=%0d first_start=%0d busy_low=%0d ready=%0b required 6 1 1 0 1",
                  obs_tile_cnt, obs_done_cnt, obs_start_cycle, obs_busy_low, obs_ready);
      end
      $display("test_basic: starts=%0d tile_cnt=%0d", obs_row.size(), obs_tile_cnt);
   endtask

   task automatic test_zero();
      run_job(0, 5, 3, 'h10, 'h20, 'h30, 0, 1);
      compared++;
      if (obs_row.size() != 0 || obs_done_cycle != 1 || obs_done_cnt != 1 || obs_tile_cnt != 0) begin
         mismatched++;
         $display("FAIL zero_job: got starts=%0d done_cycle=%0d done=%0d tile_cnt=%0d required 0 1 1 0",
                  obs_row.size(), obs_done_cycle, obs_done_cnt, obs_tile_cnt);
      end
      $display("test_zero: done_cycle=%0d", obs_done_cycle);
   endtask

   task automatic test_wrap();
      run_job(2, 1, 16, 'h1FF8, 'h40, 'h1FFC, 0, 1);
      compared++;
      if (obs_row.size() != 2) begin
         mismatched++;
         $display("FAIL wrap_starts: got %0d required 2", obs_row.size());
      end else begin
         compared++;
         if (obs_row[0] != 'h1FF8 || obs_row[1] != 'h0008 || obs_out[1] != 'h0000 || obs_col[1] != 'h40) begin
            mismatched++;
            $display("FAIL wrap_addr: got row=%0h,%0h out1=%0h col1=%0h required 1ff8,8 0 40",
                     obs_row[0], obs_row[1], obs_out[1], obs_col[1]);
         end
      end
      $display("test_wrap: second row addr=%0h", obs_row.size() > 1 ? obs_row[1] : -1);
   endtask

   task automatic test_abort();
      bit ok;
      int stray;
      drive_accept(2, 3, 8, 'h100, 'h200, 'h300, 0);
      wait_start(ok);
      @(negedge clk); sa_done = 1'b1;
      @(negedge clk); sa_done = 1'b0;
      if (ok) wait_start(ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL abort_setup: got no second sa_start required one");
      end
      @(negedge clk); sa_done = 1'b1; abort = 1'b1;
      @(negedge clk); sa_done = 1'b0; abort = 1'b0;
      compared++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || tile_cnt !== 16'd1 || job_done !== 1'b0) begin
         mismatched++;
         $display("FAIL abort_state: got ready=%b busy=%b tile_cnt=%0d done=%b required 1 0 1 0",
                  job_ready, busy, tile_cnt, job_done);
      end
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         if (job_done !== 1'b0 || sa_start !== 1'b0 || tile_cnt !== 16'd1) stray++;
         @(negedge clk);
      end
      compared++;
      if (stray != 0) begin
         mismatched++;
         $display("FAIL abort_quiet: got %0d bad cycles after abort required 0", stray);
      end
      $display("test_abort: tile_cnt=%0d", tile_cnt);
   endtask

   task automatic test_spurious_done();
      bit ok;
      int bad;
      logic [15:0] prev;
      prev = tile_cnt;
      sa_done = 1'b1;
      @(negedge clk); sa_done = 1'b0;
      compared++;
      if (tile_cnt !== prev || job_ready !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_done: got tile_cnt=%0d ready=%b busy=%b required %0d 1 0", tile_cnt, job_ready, busy, prev);
      end
      drive_accept(1, 1, 5, 'h11, 'h22, 'h33, 1);
      wait_start(ok);
      sa_done = 1'b1;
      @(negedge clk); sa_done = 1'b0;
      bad = ok ? 0 : 1;
      for (int i = 0; i < 3; i++) begin
         if (busy !== 1'b1 || job_done !== 1'b0 || tile_cnt !== 16'd0) bad++;
         @(negedge clk);
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL start_done: got %0d bad cycles after sa_done in START required 0", bad);
      end
      sa_done = 1'b1;
      @(negedge clk); sa_done = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (job_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      compared++;
      if (!ok || tile_cnt !== 16'd1) begin
         mismatched++;
         $display("FAIL spurious_finish: got done_seen=%0b tile_cnt=%0d required 1 1", ok, tile_cnt);
      end
      $display("test_spurious_done: tile_cnt=%0d", tile_cnt);
   endtask

   task automatic test_async_reset();
      bit ok;
      int seen_done;
      drive_accept(3, 3, 4, 'h10, 'h20, 'h30, 1);
      wait_start(ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (!ok || job_ready !== 1'b1 || busy !== 1'b0 || sa_start !== 1'b0 || tile_cnt !== 16'd0 ||
          sa_row_addr !== '0 || sa_out_addr !== '0 || sa_k_param !== 8'd0 || sa_out_mode !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset: got ok=%0b ready=%b busy=%b start=%b tile_cnt=%0d row=%0h out=%0h k=%0h mode=%b required reset values",
                  ok, job_ready, busy, sa_start, tile_cnt, sa_row_addr, sa_out_addr, sa_k_param, sa_out_mode);
      end
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (job_done !== 1'b0) seen_done++;
      end
      rst_n = 1'b1;
      run_job(1, 2, 8, 'h40, 'h50, 'h60, 0, 1);
      compared++;
      if (seen_done != 0 || obs_tile_cnt != 2 || obs_done_cnt != 1 || obs_col.size() != 2) begin
         mismatched++;
         $display("FAIL post_reset_job: got stray_done=%0d tile_cnt=%0d done=%0d starts=%0d required 0 2 1 2",
                  seen_done, obs_tile_cnt, obs_done_cnt, obs_col.size());
      end else begin
         compared++;
         if (obs_col[1] != 'h58 || obs_out[1] != 'h64 || obs_row[1] != 'h40) begin
            mismatched++;
            $display("FAIL post_reset_addr: got col=%0h out=%0h row=%0h required 58 64 40",
                     obs_col[1], obs_out[1], obs_row[1]);
         end
      end
      $display("test_async_reset: tile_cnt=%0d", obs_tile_cnt);
   endtask

   task automatic test_random();
      int rows, cols, k, rb, cb, ob, mode, ntiles, bad;
      int exp_row[$], exp_col[$], exp_out[$];
      for (int j = 0; j < 10; j++) begin
         rows = $urandom_range(0, 3);
         cols = $urandom_range(0, 4);
         k    = $urandom_range(0, 255);
         rb   = $urandom_range(0, AMASK);
         cb   = $urandom_range(0, AMASK);
         ob   = $urandom_range(0, AMASK);
         mode = $urandom_range(0, 1);
         exp_row.delete(); exp_col.delete(); exp_out.delete();
         for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
               exp_row.push_back((rb + r * k) & AMASK);
               exp_col.push_back((cb + c * k) & AMASK);
               exp_out.push_back((ob + (r * cols + c) * STRIDE) & AMASK);
            end
         ntiles = exp_row.size();
         run_job(rows, cols, k, rb, cb, ob, mode, 3);
         bad = 0;
         if (obs_row.size() != ntiles) bad++;
         else
            for (int i = 0; i < ntiles; i++)
               if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] || obs_out[i] != exp_out[i] ||
                   obs_k[i] != k || obs_mode[i] != mode) bad++;
         compared++;
         if (bad != 0 || obs_tile_cnt != ntiles || obs_done_cnt != 1 || !obs_ready || obs_busy_low != 0 ||
             obs_start_cycle != (ntiles == 0 ? -1 : 1) || (ntiles == 0 && obs_done_cycle != 1)) begin
            mismatched++;
            $display("FAIL random_job%0d (%0dx%0d k=%0d): got starts=%0d bad_tiles=%0d tile_cnt=%0d done=%0d first_start=%0d required starts=%0d tile_cnt=%0d done=1",
                     j, rows, cols, k, obs_row.size(), bad, obs_tile_cnt, obs_done_cnt, obs_start_cycle, ntiles, ntiles);
         end
         $display("test_random: job %0d rows=%0d cols=%0d k=%0d tiles=%0d", j, rows, cols, k, obs_tile_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_wrap();
      test_abort();
      test_spurious_done();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/acc_tile_sched.md
ACC_TILE_SCHED -- requirements
Module: acc_tile_sched

Interface
REQ-001 SHALL have parameter AW, default 13, SRAM word-address width.
REQ-002 SHALL have parameter OUT_STRIDE, default 4, output words written per tile.
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have job_valid  input  1  job descriptor valid.
REQ-006 SHALL have job_ready  output  1  scheduler can accept a job.
REQ-007 SHALL have job_row_tiles, job_col_tiles  input  8 each  tile counts.
REQ-008 SHALL have job_k  input  8  reduction length; also row/col address stride per tile.
REQ-009 SHALL have job_row_base, job_col_base, job_out_base  input  AW each  start addresses.
REQ-010 SHALL have job_out_mode  input  1  passed to SA out_mode.
REQ-011 SHALL have sa_start  output  1  one-cycle start pulse to the systolic array.
REQ-012 SHALL have sa_k_param  output  8, sa_out_mode  output  1  per-tile SA config.
REQ-013 SHALL have sa_row_addr, sa_col_addr, sa_out_addr  output  AW each  per-tile base addresses.
REQ-014 SHALL have sa_done  input  1  SA completion pulse.
REQ-015 SHALL have abort  input  1  synchronous job cancel.
REQ-016 SHALL have busy  output  1, job_done  output  1 (pulse), tile_cnt  output  16  tiles completed in current job.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> START -> WAIT -> ADV -> (START | DONE) -> IDLE.
REQ-018 job_ready SHALL be 1 only in IDLE; accept = job_valid & job_ready; descriptor latched on accept.
REQ-019 LOAD SHALL init r=0, c=0, tile_cnt=0, addresses = latched bases; sa_start SHALL assert in the cycle after LOAD (2 cycles after accept).
REQ-020 START SHALL drive sa_start=1 for exactly one cycle, then WAIT.
REQ-021 WAIT SHALL hold until sa_done=1; sa_done in any other state SHALL be ignored.
REQ-022 ADV SHALL increment tile_cnt; col-inner order: c+1 and sa_col_addr += job_k; on c wrap (c==col_tiles-1) c=0, sa_col_addr=col_base, r+1, sa_row_addr += job_k.
REQ-023 sa_out_addr SHALL advance by OUT_STRIDE every tile; all address sums SHALL wrap modulo 2^AW.
REQ-024 After last tile (r==row_tiles-1, c==col_tiles-1) ADV SHALL go to DONE; DONE SHALL pulse job_done one cycle and return to IDLE.
REQ-025 Job with row_tiles==0 or col_tiles==0 SHALL go LOAD -> DONE, pulse job_done, never assert sa_start.
REQ-026 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, no job_done, tile_cnt held; abort in IDLE ignored; abort has priority over sa_done.
REQ-027 sa_k_param, sa_out_mode SHALL be stable from LOAD until IDLE; busy=1 in every non-IDLE state.

Reset
REQ-028 On rst_n=0: state IDLE, job_ready=1, busy=0, sa_start=0, job_done=0, tile_cnt=0, all addresses/config outputs 0.
REQ-029 Reset mid-job SHALL discard the job with no job_done pulse.

Configuration
REQ-030 With ACC_SCHED_PERF_EN defined: output perf_cycles (32) counts cycles in WAIT for current job, cleared in LOAD, saturates at all-ones.
REQ-031 Without ACC_SCHED_PERF_EN: perf_cycles port and counter SHALL not exist.

Structure
REQ-032 State enum, AW default and OUT_STRIDE default SHALL live in shared package acc_pkg.
REQ-033 SHALL be one module with no sub-modules; address counters inline.

Verification
REQ-034 rows=2, cols=3, k=8, bases 0x100/0x200/0x300 -> 6 sa_start pulses; row addrs 0x100,0x100,0x100,0x108,0x108,0x108; col 0x200,0x208,0x210 repeating; out 0x300..0x314 step 4; tile_cnt=6; one job_done.
REQ-035 rows=0, cols=5 -> no sa_start; job_done exactly 2 cycles after accept.
REQ-036 row_base=0x1FF8, k=16, rows=2, cols=1 -> second sa_row_addr=0x0008 (wrap).
REQ-037 abort asserted with sa_done in WAIT of tile 2 -> IDLE next cycle, no job_done, tile_cnt=1, job_ready=1.
REQ-038 sa_done pulse while IDLE and during START -> no state change, no tile_cnt increment.
REQ-039 rst_n low during WAIT -> all outputs at reset values asynchronously; new job afterwards completes normally.
